// File: rtl/nine_way_load_sequencer_pkg.sv
// rtl/nine_way_load_sequencer_pkg.sv - shared types and constants for the nine-way load sequencer
package nine_way_load_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEL_W = 4;

    // Select code that routes the strobe to demux out9.
    localparam logic [SEL_W-1:0] LAST_SEL = 4'd8;

endpackage

// File: rtl/nine_way_index_counter.sv
// rtl/nine_way_index_counter.sv - 4-bit destination index counter with clear, saturation and last flag
module nine_way_index_counter
    import nine_way_load_sequencer_pkg::*;
#(
    parameter int NUM_DEST = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [SEL_W-1:0] index,
    output logic             last
);

    localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(NUM_DEST - 1);

    // Index register: clear wins, then increment, holding once the last destination is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (inc && (index != MAX_IDX)) begin
            index <= index + 1'b1;
        end
    end

    // Last flag marks the word that closes the frame.
    always_comb begin
        last = (index == MAX_IDX);
    end

endmodule

// File: rtl/nine_way_load_sequencer.sv
// rtl/nine_way_load_sequencer.sv - accepts a nine-word frame and issues one demux write strobe per word
module nine_way_load_sequencer
    import nine_way_load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DEST   = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [SEL_W-1:0]      wr_sel,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] index;
    logic             index_last;
    logic             accept;
    logic             frame_start;

    // Abort takes priority: a word presented in the abort cycle is dropped.
    always_comb begin
        accept      = (state == LOAD) && in_valid && !abort;
        frame_start = (state == IDLE) && start;
    end

    nine_way_index_counter #(
        .NUM_DEST (NUM_DEST)
    ) u_index_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (frame_start),
        .inc     (accept),
        .index   (index),
        .last    (index_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE lasts exactly one cycle, abort returns straight to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && index_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; done coincides with the strobe of the final word.
    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // Write port registers: strobe pulses per accept, select/data hold across bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_sel  <= index;
                wr_data <= in_data;
            end
        end
    end

endmodule
